// File: rtl/router_pkg.sv
// Shared defaults and the stored entry layout for the router output FIFO.
package router_pkg;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_LEN_LSB = 2;

    typedef struct packed {
        logic                 sop;
        logic [DEF_WIDTH-1:0] data;
    } entry_t;
endpackage

// File: rtl/router_fifo_ptr.sv
// Read/write pointer pair with wrap bit, fill level and threshold flags.
module router_fifo_ptr
    import router_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          wr_acc,
    input  logic          rd_acc,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   level
);
    localparam logic [AW:0] AF_L = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_L = (AW+1)'(AE_THRESH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // The MSB is the wrap bit: equal low bits with differing MSBs means full.
    assign wr_addr      = wr_ptr_q[AW-1:0];
    assign rd_addr      = rd_ptr_q[AW-1:0];
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_addr == rd_addr);
    assign level        = wr_ptr_q - rd_ptr_q;
    assign almost_full  = (level >= AF_L);
    assign almost_empty = (level <= AE_L);
endmodule

// File: rtl/router_pkt_fifo.sv
// Per-destination packet FIFO: tagged storage, registered read port,
// payload tracking with end-of-packet pulse, and dropped-write flag.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int LEN_LSB   = DEF_LEN_LSB,
    localparam int AW       = $clog2(DEPTH),
    localparam int LEN_W    = WIDTH - LEN_LSB
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             sop_out,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      level,
    output logic             pkt_done,
    output logic             wr_drop
);
    logic [WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]    wr_addr, rd_addr;
    logic             clr, wr_acc, rd_acc;
    logic [WIDTH:0]   rd_word;
    logic [LEN_W-1:0] len;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             sop_out_q, sop_out_d;
    logic             pkt_done_q, pkt_done_d;
    logic [LEN_W:0]   pcnt_q, pcnt_d;

    assign clr = reset || soft_reset;
    // A read on a full FIFO always succeeds, so it frees the slot this write uses.
    assign wr_acc  = write_enb && (!full || read_enb) && !clr;
    assign rd_acc  = read_enb && !empty && !clr;
    assign wr_drop = write_enb && full && !read_enb && !clr;

    router_fifo_ptr #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH),
        .AE_THRESH (AE_THRESH)
    ) u_ptr (
        .clk          (clock),
        .reset        (reset),
        .flush        (soft_reset),
        .wr_acc       (wr_acc),
        .rd_acc       (rd_acc),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level)
    );

    always_ff @(posedge clock) begin
        if (wr_acc) mem[wr_addr] <= {lfd_state, data_in};
    end

    assign rd_word = mem[rd_addr];
    assign len     = rd_word[WIDTH-1:LEN_LSB];

    // Header loads len+1 so the parity word is the one that reaches zero.
    always_comb begin
        data_out_d = data_out_q;
        sop_out_d  = sop_out_q;
        pcnt_d     = pcnt_q;
        pkt_done_d = 1'b0;
        if (soft_reset) begin
            data_out_d = '0;
            sop_out_d  = 1'b0;
            pcnt_d     = '0;
        end else if (rd_acc) begin
            data_out_d = rd_word[WIDTH-1:0];
            sop_out_d  = rd_word[WIDTH];
            if (rd_word[WIDTH]) begin
                pcnt_d = {1'b0, len} + 1'b1;
            end else if (pcnt_q != '0) begin
                pcnt_d     = pcnt_q - 1'b1;
                pkt_done_d = (pcnt_q == (LEN_W+1)'(1));
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_q <= '0;
            sop_out_q  <= 1'b0;
            pcnt_q     <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            sop_out_q  <= sop_out_d;
            pcnt_q     <= pcnt_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    assign data_out = data_out_q;
    assign sop_out  = sop_out_q;
    assign pkt_done = pkt_done_q;
endmodule
